mux_scan: RTL and testbench

Parametrised N-channel, W-bit registered channel selector: the next generation of the lab's 2-bit 4:1 mux tree. It adds a registered datapath, a manual/auto-scan mode with programmable dwell, a hold control, and status outputs. It sits between a bank of packed input channels and a single downstream consumer, for example a display or LED driver that cycles through sources.

---
 rtl/mux_scan_if.sv | 37 +++
 rtl/mux_scan.sv | 90 +++++++++
 tb/tb_mux_scan.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// mux_scan_if: channel bank / control / status bundle for mux_scan.
//   din        packed input channels, channel i at din[i*W +: W]
//   mode       0 = manual (follow sel), 1 = auto-scan
//   sel        manual channel index (values >= N are out of range)
//   hold       freezes the scan position while in scan mode
//   dout       registered selected channel data
//   cur_sel    channel index currently driving the mux
//   out_valid  dout holds a genuine sample
//   wrap       one-cycle pulse after the scan wraps from N-1 to 0
//   sel_err    manual sel was out of range on the previous edge
// master: the side that drives channels and controls (source/testbench).
// slave : the selector itself.
interface mux_scan_if #(
  parameter int W    = 2,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic [N*W-1:0] din;
  logic           mode;
  logic [SELW-1:0] sel;
  logic           hold;
  logic [W-1:0]   dout;
  logic [SELW-1:0] cur_sel;
  logic           out_valid;
  logic           wrap;
  logic           sel_err;

  modport master (
    output din, mode, sel, hold,
    input  dout, cur_sel, out_valid, wrap, sel_err
  );

  modport slave (
    input  din, mode, sel, hold,
    output dout, cur_sel, out_valid, wrap, sel_err
  );
endinterface

// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit registered channel selector with manual
// selection and an auto-scan mode that dwells DWELL cycles per channel.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mux_scan_if.slave (din/mode/sel/hold in; dout/cur_sel/
//        out_valid/wrap/sel_err out, all registered)
module mux_scan #(
  parameter int W     = 2,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_scan_if.slave   bus
);
  // Counter must hold 0..DWELL-1; keep at least one bit for DWELL=1.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0]   cnt_q;
  logic [SELW-1:0] cur_q;
  logic [W-1:0]    dout_q;
  logic            valid_q;
  logic            wrap_q;
  logic            err_q;

  logic [W-1:0]    sel_data;
  logic            sel_ok;
  logic            dwell_done;
  logic            at_last;

  // Explicit compare loop avoids indexing past N when 2^SELW > N.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (cur_q == SELW'(i)) sel_data = bus.din[i*W +: W];
    end
  end

  assign sel_ok     = (32'(bus.sel) < 32'(N));
  assign dwell_done = (cnt_q == CW'(DWELL - 1));
  assign at_last    = (cur_q == SELW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      cur_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= sel_data;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
      if (!bus.mode) begin
        // Manual: counter parked at 0 so a later switch to scan starts fresh.
        cnt_q <= '0;
        if (sel_ok) begin
          cur_q <= bus.sel;
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        err_q <= 1'b0;
        if (!bus.hold) begin
          if (!dwell_done) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q <= '0;
            if (at_last) begin
              cur_q  <= '0;
              wrap_q <= 1'b1;
            end else begin
              cur_q  <= cur_q + SELW'(1);
            end
          end
        end
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.cur_sel   = cur_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;
  localparam int DW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [1:0] sel;
  logic       hold;
  logic [7:0] din;

  always #5 clk = ~clk;

  mux_scan_if #(.W(2), .N(4), .SELW(2)) bus0 ();
  mux_scan_if #(.W(2), .N(3), .SELW(2)) bus1 ();

  assign bus0.din  = din;
  assign bus0.mode = mode;
  assign bus0.sel  = sel;
  assign bus0.hold = hold;
  assign bus1.din  = din[5:0];
  assign bus1.mode = mode;
  assign bus1.sel  = sel;
  assign bus1.hold = hold;

  mux_scan #(.W(2), .N(4), .SELW(2), .DWELL(DW)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_scan #(.W(2), .N(3), .SELW(2), .DWELL(DW)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    int   cur;
    int   cnt;
    int   dout;
    logic valid;
    logic wrap;
    logic err;
  } mstate_t;

  mstate_t m0, m1;
  int checks = 0;
  int errors = 0;
  int wraps;

  // Behavioural model: scan position advances modulo n after DW unheld cycles.
  function automatic mstate_t step(mstate_t s, logic r, logic m, int sl, logic h,
                                   logic [7:0] d, int n);
    mstate_t t;
    t = s;
    if (r) return '0;
    t.dout  = int'((d >> (2 * s.cur)) & 8'h3);
    t.valid = 1'b1;
    t.wrap  = 1'b0;
    t.err   = 1'b0;
    if (!m) begin
      t.cnt = 0;
      if (sl < n) t.cur = sl;
      else        t.err = 1'b1;
    end else if (!h) begin
      if (s.cnt < DW - 1) t.cnt = s.cnt + 1;
      else begin
        t.cnt  = 0;
        t.cur  = (s.cur + 1) % n;
        t.wrap = (s.cur == n - 1);
      end
    end
    return t;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("u0.dout",    int'(bus0.dout),      m0.dout);
    chk("u0.cur_sel", int'(bus0.cur_sel),   m0.cur);
    chk("u0.valid",   int'(bus0.out_valid), int'(m0.valid));
    chk("u0.wrap",    int'(bus0.wrap),      int'(m0.wrap));
    chk("u0.sel_err", int'(bus0.sel_err),   int'(m0.err));
    chk("u0.cnt",     int'(u0.cnt_q),       m0.cnt);
    chk("u1.dout",    int'(bus1.dout),      m1.dout);
    chk("u1.cur_sel", int'(bus1.cur_sel),   m1.cur);
    chk("u1.valid",   int'(bus1.out_valid), int'(m1.valid));
    chk("u1.wrap",    int'(bus1.wrap),      int'(m1.wrap));
    chk("u1.sel_err", int'(bus1.sel_err),   int'(m1.err));
  endtask

  // Inputs are stable here; advance the model with them, then sample #1 later.
  task automatic tick();
    @(posedge clk);
    m0 = step(m0, rst, mode, int'(sel), hold, din, 4);
    m1 = step(m1, rst, mode, int'(sel), hold, din, 3);
    #1;
    chk_all();
  endtask

  initial begin
    m0 = '0; m1 = '0;
    rst = 1'b1; mode = 1'b1; sel = 2'd0; hold = 1'b0; din = 8'b11_10_01_00;

    // Reset held two cycles in scan mode
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.dout", int'(bus0.dout), 0);
      chk("rst.cur",  int'(bus0.cur_sel), 0);
      chk("rst.valid", int'(bus0.out_valid), 0);
      chk("rst.wrap", int'(bus0.wrap), 0);
    end
    rst = 1'b0;
    tick();
    chk("rel.valid", int'(bus0.out_valid), 1);

    // Manual selection
    mode = 1'b0; sel = 2'd2;
    tick();
    chk("man.cur2", int'(bus0.cur_sel), 2);
    sel = 2'd1;
    tick();
    chk("man.cur1", int'(bus0.cur_sel), 1);
    chk("man.dout2", int'(bus0.dout), 2);
    tick();
    chk("man.dout1", int'(bus0.dout), 1);

    // Out-of-range select on the N=3 instance
    sel = 2'd3;
    tick();
    chk("oor.cur",  int'(bus1.cur_sel), 1);
    chk("oor.err",  int'(bus1.sel_err), 1);
    chk("oor.dout", int'(bus1.dout), 1);
    sel = 2'd0;
    tick();
    chk("oor.err_clr", int'(bus1.sel_err), 0);

    // Scan sweep: 12 cycles from channel 0
    mode = 1'b1; wraps = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus0.wrap) wraps++;
    end
    chk("scan.wraps", wraps, 1);
    chk("scan.cur0", int'(bus0.cur_sel), 0);

    // Reach cur_sel=1, counter=1, then hold
    for (int i = 0; i < 4; i++) tick();
    chk("hold.pre_cur", int'(bus0.cur_sel), 1);
    chk("hold.pre_cnt", int'(u0.cnt_q), 1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.cur", int'(bus0.cur_sel), 1);
      chk("hold.cnt", int'(u0.cnt_q), 1);
    end
    hold = 1'b0;
    tick();
    chk("hold.post1", int'(bus0.cur_sel), 1);
    tick();
    chk("hold.post2", int'(bus0.cur_sel), 2);

    // Advance to channel 3, switch to manual sel=0, then reset mid-scan
    for (int i = 0; i < 3; i++) tick();
    chk("sw.cur3", int'(bus0.cur_sel), 3);
    mode = 1'b0; sel = 2'd0;
    tick();
    chk("sw.cur0", int'(bus0.cur_sel), 0);
    mode = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("sw.rst_dout",  int'(bus0.dout), 0);
    chk("sw.rst_valid", int'(bus0.out_valid), 0);
    chk("sw.rst_cnt",   int'(u0.cnt_q), 0);
    rst = 1'b0;

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      mode = ($urandom_range(0, 9) < 7);
      sel  = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0);
      din  = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
